// File: rtl/uart_rx_phy.sv
// UART serial receive front end: synchronizes rxd, samples mid-bit 8N1 frames,
// and presents bytes through a single-entry valid/ready holding register.
module uart_rx_phy #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16,
    parameter int MIN_DIV   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t               state, state_n;
    logic                 rxd_m, rxd_s;
    logic [DIV_WIDTH-1:0] cnt, cnt_n, div_q, div_n, half;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 stop_ok, stop_bad;

    assign half = div_q >> 1;
    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= DIV_WIDTH'(MIN_DIV);
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + DIV_WIDTH'(1);
        div_n    = div_q;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s) begin
                    state_n = START;
                    div_n   = (div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div;
                end
            end
            START: begin
                // mid-start-bit check rejects glitches shorter than half a bit
                if (cnt == half - DIV_WIDTH'(1)) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == div_q - DIV_WIDTH'(1)) begin
                    cnt_n   = '0;
                    shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
                    bit_n   = bit_idx + BW'(1);
                    if (bit_idx == BW'(DATA_BITS - 1)) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == div_q - DIV_WIDTH'(1)) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        stop_ok = 1'b1;
                        state_n = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_n  = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // a consumer handshake in the load cycle frees the slot for the new byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= stop_bad;
            overrun     <= stop_ok && rx_valid && !rx_ready;
            if (stop_ok && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_phy.sv
// Self-checking bench for uart_rx_phy: frames are built as pin waveforms and
// results are predicted from bit-period arithmetic and a holding-register model.
module tb_uart_rx_phy;

    localparam int DB = 8;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rxd = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] div = DW'(32);
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_error, overrun, busy;

    uart_rx_phy #(.DATA_BITS(DB), .DIV_WIDTH(DW), .MIN_DIV(4)) dut (
        .clock(clock), .reset(reset), .rxd(rxd), .div(div),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_error(frame_error), .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    int   checks = 0, passed = 0;
    int   cyc = 0, fe_cnt = 0, ov_cnt = 0, fe_at = -1, ov_at = -1, valid_first = -1;
    int   ready_pulse_at = -1;
    logic ready_lvl = 1'b0;
    logic wave[$];

    function automatic int deff(input int d);
        return (d < 4) ? 4 : d;
    endfunction

    // negedges from the start-bit pin edge to the first view of rx_valid=1:
    // 2 sync + 1 detect + half bit + (DATA_BITS+1) bits to the stop sample
    function automatic int lat(input int d);
        return 3 + deff(d) / 2 + (DB + 1) * deff(d);
    endfunction

    task automatic push_level(input logic v, input int n);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] b, input logic stop, input int d);
        push_level(1'b0, deff(d));
        for (int k = 0; k < DB; k++) push_level(b[k], deff(d));
        push_level(stop, deff(d));
    endtask

    task automatic clear_stats();
        fe_cnt = 0; ov_cnt = 0; fe_at = -1; ov_at = -1; valid_first = -1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cyc++;
            rxd      = (wave.size() > 0) ? wave.pop_front() : 1'b1;
            rx_ready = (cyc == ready_pulse_at) ? 1'b1 : ready_lvl;
            #1;
            if (frame_error) begin fe_cnt++; fe_at = cyc; end
            if (overrun) begin ov_cnt++; ov_at = cyc; end
            if (rx_valid && valid_first < 0) valid_first = cyc;
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) run(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run(3);
        checks++;
        if ({rx_data, rx_valid, frame_error, overrun, busy} !== '0)
            $display("FAIL reset_outputs: got %h want 0", {rx_data, rx_valid, frame_error, overrun, busy});
        else passed++;
        reset = 1'b0;
        run(5);
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] b;
        int d, n0;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            d = (i == 0) ? 32 : int'($urandom_range(4, 20));
            div = DW'(d);
            clear_stats();
            n0 = cyc + 1;
            push_frame(b, 1'b1, d);
            run(lat(d) + deff(d));
            checks++;
            if (valid_first != n0 + lat(d))
                $display("FAIL basic_latency: got %0d want %0d (div %0d)", valid_first - n0, lat(d), d);
            else passed++;
            checks++;
            if (rx_data !== b) $display("FAIL basic_data: got %h want %h", rx_data, b); else passed++;
            checks++;
            if (fe_cnt != 0 || ov_cnt != 0 || busy !== 1'b0)
                $display("FAIL basic_flags: fe %0d ov %0d busy %b want 0 0 0", fe_cnt, ov_cnt, busy);
            else passed++;
            ready_pulse_at = cyc + 1;
            run(2);
            checks++;
            if (rx_valid !== 1'b0) $display("FAIL basic_consume: rx_valid %b want 0", rx_valid); else passed++;
        end
    endtask

    task automatic test_glitch();
        int g;
        div = DW'(32);
        for (int i = 0; i < 3; i++) begin
            g = (i == 0) ? 8 : int'($urandom_range(1, 14));
            clear_stats();
            push_level(1'b0, g);
            run(60);
            checks++;
            if (valid_first >= 0 || fe_cnt != 0 || ov_cnt != 0 || busy !== 1'b0)
                $display("FAIL glitch_%0d: valid_at %0d fe %0d ov %0d busy %b want none", g, valid_first, fe_cnt, ov_cnt, busy);
            else passed++;
        end
    endtask

    task automatic test_frame_error();
        int n0;
        div = DW'(32);
        clear_stats();
        n0 = cyc + 1;
        push_frame(8'h3C, 1'b0, 32);
        push_level(1'b0, 100);
        run_to(n0 + lat(32) + 5);
        checks++;
        if (fe_cnt != 1 || fe_at != n0 + lat(32))
            $display("FAIL ferr_pulse: count %0d at %0d want 1 at %0d", fe_cnt, fe_at - n0, lat(32));
        else passed++;
        checks++;
        if (rx_valid !== 1'b0 || ov_cnt != 0) $display("FAIL ferr_valid: rx_valid %b ov %0d want 0 0", rx_valid, ov_cnt); else passed++;
        run_to(n0 + 419);
        checks++;
        if (busy !== 1'b1 || fe_cnt != 1) $display("FAIL ferr_break_busy: busy %b fe %0d want 1 1", busy, fe_cnt); else passed++;
        run_to(n0 + 425);
        checks++;
        if (busy !== 1'b0 || fe_cnt != 1) $display("FAIL ferr_release: busy %b fe %0d want 0 1", busy, fe_cnt); else passed++;
        clear_stats();
        n0 = cyc + 1;
        push_frame(8'h5A, 1'b1, 32);
        run(lat(32) + 32);
        checks++;
        if (valid_first != n0 + lat(32) || rx_data !== 8'h5A || fe_cnt != 0)
            $display("FAIL ferr_next_byte: data %h at %0d fe %0d want 5a at %0d", rx_data, valid_first - n0, fe_cnt, lat(32));
        else passed++;
        ready_pulse_at = cyc + 1;
        run(2);
    endtask

    task automatic test_overrun();
        int n0, n1;
        div = DW'(32);
        ready_lvl = 1'b0;
        clear_stats();
        n0 = cyc + 1;
        n1 = n0 + 10 * 32;
        push_frame(8'h11, 1'b1, 32);
        push_frame(8'h22, 1'b1, 32);
        run_to(n1 + lat(32) + 32);
        checks++;
        if (ov_cnt != 1 || ov_at != n1 + lat(32))
            $display("FAIL overrun_pulse: count %0d at %0d want 1 at %0d", ov_cnt, ov_at - n1, lat(32));
        else passed++;
        checks++;
        if (rx_data !== 8'h11 || rx_valid !== 1'b1 || fe_cnt != 0)
            $display("FAIL overrun_hold: data %h valid %b fe %0d want 11 1 0", rx_data, rx_valid, fe_cnt);
        else passed++;
        ready_pulse_at = cyc + 1;
        run(2);
        checks++;
        if (rx_valid !== 1'b0) $display("FAIL overrun_consume: rx_valid %b want 0", rx_valid); else passed++;
    endtask

    task automatic test_ready_on_load();
        int n0;
        div = DW'(32);
        clear_stats();
        push_frame(8'h11, 1'b1, 32);
        run(lat(32) + 32);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) $display("FAIL rol_first: valid %b data %h want 1 11", rx_valid, rx_data); else passed++;
        n0 = cyc + 1;
        push_frame(8'h33, 1'b1, 32);
        ready_pulse_at = n0 + lat(32) - 1;
        run_to(n0 + lat(32) - 1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) $display("FAIL rol_before: valid %b data %h want 1 11", rx_valid, rx_data); else passed++;
        run(1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h33 || ov_cnt != 0)
            $display("FAIL rol_load: valid %b data %h ov %0d want 1 33 0", rx_valid, rx_data, ov_cnt);
        else passed++;
        run(40);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h33) $display("FAIL rol_hold: valid %b data %h want 1 33", rx_valid, rx_data); else passed++;
    endtask

    task automatic test_reset_mid();
        int n0;
        div = DW'(32);
        clear_stats();
        n0 = cyc + 1;
        push_frame(8'hFF, 1'b1, 32);
        run_to(n0 + 3 + 16 + 4 * 32 + 8);
        checks++;
        if (busy !== 1'b1 || rx_valid !== 1'b1) $display("FAIL rmid_pre: busy %b valid %b want 1 1", busy, rx_valid); else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if ({rx_data, rx_valid, frame_error, overrun, busy} !== '0)
            $display("FAIL rmid_async: got %h want 0", {rx_data, rx_valid, frame_error, overrun, busy});
        else passed++;
        wave.delete();
        run(3);
        reset = 1'b0;
        run(5);
        clear_stats();
        n0 = cyc + 1;
        push_frame(8'h81, 1'b1, 32);
        run(lat(32) + 32);
        checks++;
        if (valid_first != n0 + lat(32) || rx_data !== 8'h81 || fe_cnt != 0)
            $display("FAIL rmid_after: data %h at %0d fe %0d want 81 at %0d", rx_data, valid_first - n0, fe_cnt, lat(32));
        else passed++;
        ready_pulse_at = cyc + 1;
        run(2);
        div = DW'(2);
        clear_stats();
        n0 = cyc + 1;
        push_frame(8'h0F, 1'b1, 2);
        run(lat(2) + 4);
        checks++;
        if (valid_first != n0 + lat(2) || rx_data !== 8'h0F)
            $display("FAIL min_div: data %h at %0d want 0f at %0d", rx_data, valid_first - n0, lat(2));
        else passed++;
        ready_pulse_at = cyc + 1;
        run(2);
        div = DW'(32);
        reset = 1'b1;
        push_level(1'b0, 400);
        run(3);
        clear_stats();
        reset = 1'b0;
        run(380);
        checks++;
        if (fe_cnt != 1 || busy !== 1'b1 || rx_valid !== 1'b0)
            $display("FAIL reset_low_rxd: fe %0d busy %b valid %b want 1 1 0", fe_cnt, busy, rx_valid);
        else passed++;
        run(30);
        checks++;
        if (busy !== 1'b0 || fe_cnt != 1) $display("FAIL reset_low_release: busy %b fe %0d want 0 1", busy, fe_cnt); else passed++;
    endtask

    // random frames, gaps and ready pattern against a cycle-level holding-register model
    task automatic test_stream();
        int         d, n0, total, ev_t[$];
        logic [7:0] ev_b[$], b, m_data;
        logic       m_valid, m_ov, ok;
        d = int'($urandom_range(4, 12));
        div = DW'(d);
        for (int f = 0; f < 8; f++) begin
            b = 8'($urandom);
            n0 = cyc + 1 + wave.size();
            ev_t.push_back(n0 + lat(d) - 1);
            ev_b.push_back(b);
            push_frame(b, 1'b1, d);
            push_level(1'b1, int'($urandom_range(0, 2 * d)));
        end
        total = wave.size() + lat(d);
        m_valid = 1'b0; m_data = '0; m_ov = 1'b0;
        for (int i = 0; i < total; i++) begin
            ready_lvl = ($urandom_range(0, 3) == 0);
            run(1);
            ok = (rx_valid === m_valid) && (!m_valid || rx_data === m_data) &&
                 (overrun === m_ov) && (frame_error === 1'b0);
            checks++;
            if (!ok) begin
                if (checks - passed < 10)
                    $display("FAIL stream cyc %0d: valid %b data %h ov %b fe %b want %b %h %b 0",
                             cyc, rx_valid, rx_data, overrun, frame_error, m_valid, m_data, m_ov);
            end else passed++;
            m_ov = 1'b0;
            if (ev_t.size() > 0 && ev_t[0] == cyc) begin
                void'(ev_t.pop_front());
                b = ev_b.pop_front();
                if (!m_valid || rx_ready) begin
                    m_valid = 1'b1;
                    m_data  = b;
                end else m_ov = 1'b1;
            end else if (m_valid && rx_ready) m_valid = 1'b0;
        end
        ready_lvl = 1'b0;
        checks++;
        if (ev_t.size() != 0) $display("FAIL stream_events: %0d loads unobserved want 0", ev_t.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_ready_on_load();
        test_reset_mid();
        test_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_phy.md
Name: uart_rx_phy

Overview:
Serial receive front end of the UART peripheral. It turns the asynchronous rxd pin into bytes for the UART RX FIFO, using a valid/ready handshake toward the FIFO. The block sits between the board pin (rxd, looped to txd in echo mode) and the uart block's RX FIFO. It is the upstream stage that makes the processor-visible rx_data register possible.

Parameters:
DATA_BITS, 8, payload bits per frame, LSB first, no parity, 1 stop bit
DIV_WIDTH, 16, width of the baud divisor input
MIN_DIV, 4, smallest effective divisor; smaller div values are clamped to MIN_DIV

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
rxd  input  1  raw serial input, idle high, asynchronous to clock
div  input  DIV_WIDTH  clock cycles per bit (115200*32 Hz clock at 115200 baud -> 32)
rx_data  output  DATA_BITS  received byte, held while rx_valid=1
rx_valid  output  1  holding register contains an unconsumed byte
rx_ready  input  1  consumer accepts rx_data this cycle
frame_error  output  1  1-cycle pulse: stop bit sampled low
overrun  output  1  1-cycle pulse: completed byte dropped because holding register was full
busy  output  1  high in any state other than IDLE

Behaviour:
- The clock is the single clock. reset is asynchronous and active-high.
- Reset: 2-FF synchronizer flops = 1, state = IDLE, counters = 0, rx_data = 0, rx_valid = 0, frame_error = 0, overrun = 0, busy = 0.
- rxd passes through a 2-FF synchronizer (rxd_s). All decisions use rxd_s only.
- div is latched into div_q on leaving IDLE. Changes to div mid-frame have no effect. If div < MIN_DIV, div_q = MIN_DIV.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: the first cycle with rxd_s=0 is cycle E. On E, go to START with cnt=0.
- START: cnt increments each cycle. When cnt == div_q/2 - 1 (at cycle E + div_q/2), sample rxd_s:
  - if 1, it is a false start: return to IDLE, no pulses;
  - if 0, go to DATA with cnt=0 and bit_idx=0.
- DATA: cnt counts 0..div_q-1. At cnt == div_q-1, shift rxd_s into the shift register MSB side, so the LSB is received first. Then cnt=0 and bit_idx++. After DATA_BITS samples, go to STOP.
- Bit k is sampled at cycle E + div_q/2 + (k+1)*div_q.
- STOP: sampled at cnt == div_q-1, which is cycle E + div_q/2 + (DATA_BITS+1)*div_q.
  - Sample 1: attempt load into the holding register, go to IDLE.
  - Sample 0: frame_error=1 for one cycle, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxd_s=1, then go to IDLE. A line break therefore yields exactly one frame_error.
- Holding register load happens on the cycle after the stop sample:
  - if rx_valid=0, or rx_valid=1 with rx_ready=1 on that cycle: rx_data <= new byte and rx_valid=1.
  - if rx_valid=1 and rx_ready=0: overrun=1 for one cycle, the new byte is dropped, and rx_data keeps the old byte.
- Handshake: a byte is consumed on any cycle with rx_valid & rx_ready. rx_valid then drops next cycle, unless a load happens in the same cycle. rx_data is stable whenever rx_valid=1 and no handshake has occurred.
- Latency at div=32, 8 bits: stop sample at E+304, rx_valid=1 from E+305. E itself is 2-3 clocks after the pin edge (synchronizer).
- Reset asserted mid-frame: immediate return to the reset values; the partial byte is lost. If rxd is held low when reset releases, the block sees a start and then a low stop bit. Result: one frame_error, then WAIT_IDLE.
- frame_error and overrun are never asserted in the same cycle.

Test Plan:
1. div=32, send 0xA5 (8N1) -> rx_data=0xA5; rx_valid rises at E+305; no error pulses; busy low after STOP.
2. Low glitch on rxd of 8 cycles, div=32 -> START sample at E+16 reads 1; back to IDLE; no rx_valid, no pulses.
3. Send 0x3C with stop bit forced 0, then hold rxd low 100 cycles, then release -> one frame_error pulse; rx_valid stays 0; busy stays high until rxd_s=1; a following byte 0x5A is received correctly.
4. rx_ready=0, send 0x11 then 0x22 back to back -> after the second frame, a 1-cycle overrun pulse; rx_data=0x11; rx_valid=1. Then rx_ready=1 for 1 cycle -> rx_valid=0 next cycle.
5. rx_valid=1 holding 0x11; rx_ready=1 exactly on the load cycle of 0x33 -> rx_data=0x33; rx_valid stays 1; no overrun.
6. Assert reset after 4 data bits of 0xFF -> all outputs 0 asynchronously. Release with rxd=1, send 0x81 -> rx_data=0x81. Also: div=2 with 0x0F -> decoded with div_q=4 timing.
